// File: rtl/mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// mem_loader_pkg
// Purpose : shared definitions for the somador datapath front end: the RAM
//           geometry used by both the loader and the accumulator, and the
//           loader FSM state encoding (3-bit).
// Ports   : none (package).
// ---------------------------------------------------------------------------
package mem_loader_pkg;

    // RAM geometry shared with the accumulator (32 x 16 synchronous RAM)
    localparam int unsigned RAM_DATA_W = 16;
    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DEPTH  = 32;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SETUP = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage : mem_loader_pkg

// File: rtl/mem_loader_csum.sv
// ---------------------------------------------------------------------------
// mem_loader_csum
// Purpose : running modular sum of the words written into the RAM.
//           Only instantiated when LOADER_CHECKSUM_EN is defined.
// Ports   : clk     - system clock
//           reset   - synchronous active-high reset
//           i_clr   - clear the sum (start accept)
//           i_add   - add i_data this cycle (WRITE cycle)
//           i_data  - word being written
//           o_sum   - registered running sum, mod 2**DATA_W
// ---------------------------------------------------------------------------
module mem_loader_csum
    import mem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_add,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    // Clear takes priority; the adder wraps naturally at DATA_W bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule : mem_loader_csum

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
// Purpose : accepts a valid/ready word stream and writes DEPTH consecutive
//           words into the synchronous RAM at addresses 0..DEPTH-1, using a
//           WAIT/SETUP/WRITE/HOLD sequence per word so that address and data
//           are stable for a full cycle before, during and after the write
//           strobe. Pulses done when the memory is loaded.
// Config  : LOADER_CHECKSUM_EN - when defined, checksum is the running sum of
//           written words (cleared at start accept); otherwise tied to 0.
// Ports   : clk       - system clock, rising edge
//           reset     - synchronous active-high reset
//           start     - begin a load (sampled only in IDLE)
//           in_data   - stream word
//           in_valid  - in_data valid
//           in_ready  - loader accepts a word this cycle
//           address   - RAM address
//           dataout   - RAM write data
//           wren      - RAM write enable
//           busy      - start accept through done pulse inclusive
//           done      - one-cycle pulse after the last write
//           checksum  - running sum of written words
// ---------------------------------------------------------------------------
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataout,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_dataout;
    logic              r_wren;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;

    // Loader FSM; every output is a register updated on the state transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_address  <= '0;
            r_dataout  <= '0;
            r_wren     <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                // Address and data only ever change on the accept edge
                ST_WAIT: begin
                    if (in_valid && r_in_ready) begin
                        r_dataout  <= in_data;
                        r_address  <= r_cnt;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_wren  <= 1'b1;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wren  <= 1'b0;
                    r_state <= ST_HOLD;
                end
                // cnt stops at DEPTH-1, so a full 2**ADDR_W load never wraps
                ST_HOLD: begin
                    if (r_cnt == LAST_CNT) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt      <= r_cnt + ADDR_W'(1);
                        r_in_ready <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign address  = r_address;
    assign dataout  = r_dataout;
    assign wren     = r_wren;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef LOADER_CHECKSUM_EN
    logic w_csum_clr;
    logic w_csum_add;

    // Clear on the start accept edge, accumulate the latched word in WRITE
    assign w_csum_clr = (r_state == ST_IDLE) && start;
    assign w_csum_add = (r_state == ST_WRITE);

    mem_loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_csum_clr),
        .i_add  (w_csum_add),
        .i_data (r_dataout),
        .o_sum  (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule : mem_loader

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
// Purpose : drives mem_loader with a stream source, models the RAM it writes,
//           and checks contents, checksum, latency and write-strobe timing
//           against expectations computed from the load description.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 5;
    localparam int unsigned DEP = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] address;
    logic [DW-1:0] dataout;
    logic          wren;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    int total = 0;
    int bad   = 0;

    mem_loader #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .address  (address),
        .dataout  (dataout),
        .wren     (wren),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    // The RAM being loaded
    logic [DW-1:0] ram [DEP];
    int            wr_count = 0;

    always @(posedge clk) begin
        if (wren) begin
            ram[address] <= dataout;
            wr_count     <= wr_count + 1;
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 = value equals address, 1 = constant cval, 2 = random words
    typedef struct {
        int            kind;
        logic [DW-1:0] cval;
        int            gap_pct;
        int            abort_at;
        bit            poke_start;
        bit            use_model;
        logic [DW-1:0] exp_csum;
        bit            check_lat;
    } vec_t;

    task automatic check_idle_outputs(input string tag);
        chk(wren == 1'b0,     {tag, "_wren"},     longint'(wren), 0);
        chk(busy == 1'b0,     {tag, "_busy"},     longint'(busy), 0);
        chk(done == 1'b0,     {tag, "_done"},     longint'(done), 0);
        chk(in_ready == 1'b0, {tag, "_in_ready"}, longint'(in_ready), 0);
        chk(address == '0,    {tag, "_address"},  longint'(address), 0);
        chk(dataout == '0,    {tag, "_dataout"},  longint'(dataout), 0);
        chk(checksum == '0,   {tag, "_checksum"}, longint'(checksum), 0);
    endtask

    task automatic run_load(input vec_t v);
        logic [DW-1:0] words [DEP];
        logic [DW-1:0] sum;
        logic [DW-1:0] exp_csum;
        logic [DW-1:0] csum_at_done;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        bit            p_wren;
        bit            last_hs;
        bit            aborted;
        int            idx;
        int            cyc;
        int            dones;
        int            done_cyc;
        int            wr_base;

        sum = '0;
        for (int i = 0; i < int'(DEP); i++) begin
            case (v.kind)
                0:       words[i] = DW'(i);
                1:       words[i] = v.cval;
                default: words[i] = DW'($urandom);
            endcase
            sum = sum + words[i];
        end
`ifdef LOADER_CHECKSUM_EN
        exp_csum = v.use_model ? sum : v.exp_csum;
`else
        exp_csum = '0;
`endif
        wr_base      = wr_count;
        idx          = 0;
        last_hs      = 1'b0;
        aborted      = 1'b0;
        cyc          = 0;
        dones        = 0;
        done_cyc     = -1;
        csum_at_done = '0;
        p_wren       = wren;
        p_addr       = address;
        p_data       = dataout;

        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;

        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;

            if (cyc == 1) begin
                chk(busy == 1'b1, "busy_after_start", longint'(busy), 1);
                chk(checksum == '0, "csum_clear_at_start", longint'(checksum), 0);
            end

            // Write-strobe protocol monitor
            if (wren && !p_wren)
                chk(address == p_addr, "addr_stable_before_wren", longint'(address), longint'(p_addr));
            if (p_wren) begin
                chk(!wren, "wren_width", longint'(wren), 0);
                chk(address == p_addr && dataout == p_data, "addr_data_hold_after_wren",
                    {32'(address), 32'(dataout)}, {32'(p_addr), 32'(p_data)});
            end
            if (!busy)
                chk(!in_ready, "in_ready_when_idle", longint'(in_ready), 0);
            p_wren = wren;
            p_addr = address;
            p_data = dataout;

            // Reset in the WRITE cycle of the chosen word
            if (v.abort_at >= 0 && wren && address == AW'(v.abort_at)) begin
                reset    = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check_idle_outputs("abort");
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end

            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    csum_at_done = checksum;
                    chk(busy == 1'b1, "busy_in_done_cycle", longint'(busy), 1);
                end
                if (v.poke_start) start = 1'b1;
            end else if (v.poke_start && busy && ($urandom_range(7) == 0)) begin
                start = 1'b1;
            end

            // Stream source: hold a presented word until it is accepted
            if (last_hs) in_valid = 1'b0;
            if (!in_valid && idx < int'(DEP) && busy)
                in_valid = (int'($urandom_range(99)) >= v.gap_pct);
            if (in_valid) in_data = words[idx];
            last_hs = in_valid && in_ready;
            if (last_hs) idx++;

            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        start    = 1'b0;
        in_valid = 1'b0;

        if (aborted) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk(!done && !busy, "no_done_after_abort", {32'(done), 32'(busy)}, 0);
            end
            return;
        end

        chk(done_cyc >= 0, "done_timeout", longint'(done_cyc), 0);
        chk(dones == 1, "done_count", longint'(dones), 1);
        chk(csum_at_done == exp_csum, "checksum_at_done", longint'(csum_at_done), longint'(exp_csum));
        chk(checksum == exp_csum, "checksum_held", longint'(checksum), longint'(exp_csum));
        chk(busy == 1'b0, "busy_after_done", longint'(busy), 0);
        chk(wr_count - wr_base == int'(DEP), "write_count", longint'(wr_count - wr_base), longint'(DEP));
        if (v.check_lat)
            chk(done_cyc + 1 == 1 + 4 * int'(DEP) + 1, "start_to_done_latency",
                longint'(done_cyc + 1), longint'(1 + 4 * int'(DEP) + 1));
        for (int i = 0; i < int'(DEP); i++)
            chk(ram[i] == words[i], $sformatf("ram[%0d]", i), longint'(ram[i]), longint'(words[i]));

        // A source presenting data while idle must never be accepted
        if (v.poke_start) begin
            wr_base  = wr_count;
            in_valid = 1'b1;
            in_data  = 16'h5A5A;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk(!in_ready && !busy, "idle_no_handshake", {32'(in_ready), 32'(busy)}, 0);
            end
            in_valid = 1'b0;
            @(negedge clk);
            chk(wr_count == wr_base, "idle_no_write", longint'(wr_count - wr_base), 0);
        end
    endtask

    initial begin
        vec_t vecs [6];

        vecs[0] = '{kind: 0, cval: 16'h0000, gap_pct: 0,  abort_at: -1, poke_start: 1'b0,
                    use_model: 1'b0, exp_csum: 16'h01F0, check_lat: 1'b1};
        vecs[1] = '{kind: 1, cval: 16'hFFFF, gap_pct: 50, abort_at: -1, poke_start: 1'b0,
                    use_model: 1'b0, exp_csum: 16'hFFE0, check_lat: 1'b0};
        vecs[2] = '{kind: 0, cval: 16'h0000, gap_pct: 0,  abort_at: 10, poke_start: 1'b0,
                    use_model: 1'b0, exp_csum: 16'h0000, check_lat: 1'b0};
        vecs[3] = '{kind: 1, cval: 16'hA5A5, gap_pct: 0,  abort_at: -1, poke_start: 1'b0,
                    use_model: 1'b0, exp_csum: 16'hB4A0, check_lat: 1'b1};
        vecs[4] = '{kind: 2, cval: 16'h0000, gap_pct: 30, abort_at: -1, poke_start: 1'b1,
                    use_model: 1'b1, exp_csum: 16'h0000, check_lat: 1'b0};
        vecs[5] = '{kind: 2, cval: 16'h0000, gap_pct: 0,  abort_at: -1, poke_start: 1'b1,
                    use_model: 1'b1, exp_csum: 16'h0000, check_lat: 1'b1};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // in_valid while idle after reset is ignored
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (3) @(negedge clk);
        chk(!in_ready && wr_count == 0, "post_reset_idle", {32'(in_ready), 32'(wr_count)}, 0);
        in_valid = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_load(vecs[t]);
            repeat (2) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_loader
